// File: rtl/card_pkg.sv
// card_pkg: shared constants and types for the card dealer.
//   DECK_SIZE/SUIT_SIZE  deck geometry (6-bit so they compare cleanly with indices)
//   suit_e               suit encoding used in bits 5:4 of a card code
//   card_t               7-bit card code {used, suit, value}
//   dealer_state_e       probe FSM states
//   LFSR_TAPS            feedback taps (bits 15,13,12,10) of the 16-bit LFSR
//   fold52/card_encode   candidate wrap and index -> card code
package card_pkg;

  localparam logic [5:0]  DECK_SIZE = 6'd52;
  localparam logic [5:0]  DECK_LAST = 6'd51;
  localparam logic [5:0]  SUIT_SIZE = 6'd13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {SPADE = 2'b00, HEART = 2'b01, DIAMOND = 2'b10, CLUB = 2'b11} suit_e;

  typedef struct packed {
    logic       used;
    suit_e      suit;
    logic [3:0] value;
  } card_t;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PROBE = 2'd1, ST_DONE = 2'd2} dealer_state_e;

  // Random 6-bit value into 0..51; values 52..63 fold onto 0..11.
  function automatic logic [5:0] fold52(input logic [5:0] v);
    return (v >= DECK_SIZE) ? v - DECK_SIZE : v;
  endfunction

  // Deck index -> card code. Suit/rank found by range compare instead of a divider.
  function automatic card_t card_encode(input logic [5:0] idx);
    card_t      c;
    logic [5:0] rank;
    c.used = 1'b1;
    if (idx < SUIT_SIZE) begin
      c.suit = SPADE;   rank = idx;
    end else if (idx < 6'd26) begin
      c.suit = HEART;   rank = idx - SUIT_SIZE;
    end else if (idx < 6'd39) begin
      c.suit = DIAMOND; rank = idx - 6'd26;
    end else begin
      c.suit = CLUB;    rank = idx - 6'd39;
    end
    if (rank == 6'd0)      c.value = 4'd11;  // ace
    else if (rank >= 6'd9) c.value = 4'd10;  // 10, J, Q, K
    else                   c.value = rank[3:0] + 4'd1;
    return c;
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: game-FSM <-> dealer bundle.
//   master (game FSM): drives shuffle/seed/draw_req, receives card results.
//   slave  (dealer)  : the reverse.
interface card_dealer_if;
  logic        shuffle;
  logic [15:0] seed;
  logic        draw_req;
  logic        draw_ready;
  logic        card_valid;
  logic [5:0]  card_idx;
  logic [6:0]  card_code;
  logic [5:0]  cards_left;
  logic        draw_err;

  modport master (output shuffle, seed, draw_req,
                  input  draw_ready, card_valid, card_idx, card_code, cards_left, draw_err);
  modport slave  (input  shuffle, seed, draw_req,
                  output draw_ready, card_valid, card_idx, card_code, cards_left, draw_err);
endinterface

// File: rtl/card_lfsr.sv
// card_lfsr: 16-bit Fibonacci LFSR, shifts left every cycle.
//   clk, rst  clock, synchronous active-high reset (loads SEED_DEFAULT)
//   load      reload from seed this cycle (seed 0 replaced by 1)
//   seed      load value
//   rnd       low 6 bits of the current state, used as the draw candidate
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [5:0]  rnd
);

  // A zero state would lock up the register, so both load paths avoid it.
  localparam logic [15:0] RST_VAL = (SEED_DEFAULT == 16'h0) ? 16'h0001 : SEED_DEFAULT;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    if (load) lfsr_d = (seed == 16'h0) ? 16'h0001 : seed;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= RST_VAL;
    else     lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[5:0];

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals never-repeated cards from a 52-card deck.
//   clk, rst  clock, synchronous active-high reset
//   bus       card_dealer_if.slave: shuffle/seed/draw_req in;
//             draw_ready, card_valid, card_idx, card_code, cards_left, draw_err out
// A draw registers an LFSR-derived candidate, then PROBE walks forward
// (wrapping 51->0) until an unused card is found; DONE pulses card_valid.
// Build option DEALER_AUTO_RESHUFFLE_EN: a draw on an empty deck silently
// refills it and deals; without it the draw is rejected with a draw_err pulse.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'h0001
) (
  input logic          clk,
  input logic          rst,
  card_dealer_if.slave bus
);

  dealer_state_e state_q, state_d;
  logic [51:0]   used_q,  used_d;
  logic [5:0]    left_q,  left_d;
  logic [5:0]    cand_q,  cand_d;
  logic [5:0]    idx_q,   idx_d;
  card_t         code_q,  code_d;
  logic          err_q,   err_d;
  logic [5:0]    rnd;
  logic          accept;

  card_lfsr #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (bus.shuffle),
    .seed (bus.seed),
    .rnd  (rnd)
  );

  assign bus.draw_ready = (state_q == ST_IDLE) && !bus.shuffle;
  assign accept         = bus.draw_req && bus.draw_ready;

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    left_d  = left_q;
    cand_d  = cand_q;
    idx_d   = idx_q;
    code_d  = code_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (left_q != 6'd0) begin
            cand_d  = fold52(rnd);
            state_d = ST_PROBE;
          end else begin
`ifdef DEALER_AUTO_RESHUFFLE_EN
            // Refill without touching the LFSR, then deal as usual.
            used_d  = '0;
            left_d  = DECK_SIZE;
            cand_d  = fold52(rnd);
            state_d = ST_PROBE;
`else
            err_d   = 1'b1;
`endif
          end
        end
      end
      ST_PROBE: begin
        if (!used_q[cand_q]) begin
          used_d[cand_q] = 1'b1;
          left_d         = left_q - 6'd1;
          idx_d          = cand_q;
          code_d         = card_encode(cand_q);
          state_d        = ST_DONE;
        end else begin
          cand_d = (cand_q == DECK_LAST) ? 6'd0 : cand_q + 6'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Shuffle overrides everything; an in-flight draw is dropped and the
    // last dealt card stays visible.
    if (bus.shuffle) begin
      state_d = ST_IDLE;
      used_d  = '0;
      left_d  = DECK_SIZE;
      idx_d   = idx_q;
      code_d  = code_q;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      used_q  <= '0;
      left_q  <= DECK_SIZE;
      cand_q  <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      left_q  <= left_d;
      cand_q  <= cand_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign bus.card_valid = (state_q == ST_DONE);
  assign bus.card_idx   = idx_q;
  assign bus.card_code  = code_q;
  assign bus.cards_left = left_q;
  assign bus.draw_err   = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench for card_dealer. A reference model runs on
// the falling edge: it tracks the LFSR, used mask and busy state, pushes the
// expected card on each accepted draw and pops/compares on card_valid.
module tb_card_dealer;

  localparam logic [15:0] SEED_DEF = 16'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  card_dealer_if bus ();

  card_dealer #(.SEED_DEFAULT(SEED_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int idx;
    int code;
    int left;
    int t;
    int lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [15:0] lfsr_m;
  logic [51:0] used_m;
  logic [51:0] seen;
  int          left_m   = 52;
  bit          busy     = 1'b0;
  bit          err_pend = 1'b0;
  int          cyc      = 0;
  int          n_valid  = 0;
  int          n_err    = 0;
  int          last_lat = 0;
  int          obs_code[52];
  int          c, k;

  function automatic int enc(input int idx);
    int s, r, v;
    s = idx / 13;
    r = idx % 13;
    v = (r == 0) ? 11 : (r >= 9) ? 10 : r + 1;
    return 64 + s * 16 + v;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) chk("draw_ready", bus.draw_ready, !busy && !bus.shuffle);
    if (!rst && (bus.draw_err || err_pend)) begin
      chk("draw_err", bus.draw_err, err_pend);
      if (bus.draw_err) n_err++;
    end
    err_pend = 1'b0;
    if (!rst && bus.card_valid) begin
      n_valid++;
      if (sbq.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        last_lat = cyc - e.t;
        chk("card_idx",   bus.card_idx,   e.idx);
        chk("card_code",  bus.card_code,  e.code);
        chk("cards_left", bus.cards_left, e.left);
        chk("latency",    last_lat,       e.lat);
        chk("dup_idx",    seen[bus.card_idx], 0);
        seen[bus.card_idx] = 1'b1;
        obs_code[bus.card_idx] = int'(bus.card_code);
      end
      busy = 1'b0;
    end
    if (rst) begin
      lfsr_m = SEED_DEF; used_m = '0; seen = '0; left_m = 52; busy = 1'b0; sbq.delete();
    end else if (bus.shuffle) begin
      lfsr_m = (bus.seed == 16'h0) ? 16'h0001 : bus.seed;
      used_m = '0; seen = '0; left_m = 52; busy = 1'b0; sbq.delete();
    end else begin
      if (bus.draw_req && !busy) begin
        if (left_m == 0) begin
`ifdef DEALER_AUTO_RESHUFFLE_EN
          used_m = '0; seen = '0; left_m = 52;
`else
          err_pend = 1'b1;
`endif
        end
        if (left_m > 0) begin
          c = int'(lfsr_m[5:0]);
          if (c >= 52) c -= 52;
          k = 0;
          while (used_m[c]) begin
            c = (c == 51) ? 0 : c + 1;
            k++;
          end
          used_m[c] = 1'b1;
          left_m--;
          sbq.push_back('{idx: c, code: enc(c), left: left_m, t: cyc, lat: 2 + k});
          busy = 1'b1;
        end
      end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  task automatic shuffle_deck(input logic [15:0] s);
    bus.seed    = s;
    bus.shuffle = 1'b1;
    @(posedge clk); #1;
    bus.shuffle = 1'b0;
  endtask

  task automatic draw_one();
    int w;
    w = 0;
    while (!bus.draw_ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 60) chk("ready_timeout", 0, 1);
    bus.draw_req = 1'b1;
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
    w = 0;
    while (busy && w < 60) begin
      @(posedge clk); #1; w++;
    end
    if (busy) chk("valid_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.card_valid, 0);
    chk({tag, "_err"},   bus.draw_err,   0);
    chk({tag, "_idx"},   bus.card_idx,   0);
    chk({tag, "_code"},  bus.card_code,  0);
    chk({tag, "_left"},  bus.cards_left, 52);
    chk({tag, "_ready"}, bus.draw_ready, 1);
  endtask

  int v0, e0, exp_last;

  initial begin
    rst = 1'b1; bus.shuffle = 1'b0; bus.seed = '0; bus.draw_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    // Full deal with seed ACE1.
    shuffle_deck(16'hACE1);
    v0 = n_valid;
    repeat (52) draw_one();
    chk("deal_count",  n_valid - v0, 52);
    chk("deal_left0",  bus.cards_left, 0);
    chk("deal_all",    &seen, 1);
    chk("code_idx0",   obs_code[0],  'h4B);
    chk("code_idx13",  obs_code[13], 'h5B);
    chk("code_idx22",  obs_code[22], 'h5A);
    chk("code_idx51",  obs_code[51], 'h7A);
    chk("code_idx27",  obs_code[27], 'h62);

    // Draw on an empty deck.
    v0 = n_valid; e0 = n_err;
    draw_one();
    repeat (3) begin @(posedge clk); #1; end
`ifdef DEALER_AUTO_RESHUFFLE_EN
    chk("empty_valid", n_valid - v0, 1);
    chk("empty_left",  bus.cards_left, 51);
    chk("empty_err",   n_err - e0, 0);
`else
    chk("empty_err",   n_err - e0, 1);
    chk("empty_valid", n_valid - v0, 0);
    chk("empty_left",  bus.cards_left, 0);
`endif

    // Collision-heavy tail: last card must be the single unused one.
    shuffle_deck(16'h0001);
    repeat (51) draw_one();
    exp_last = -1;
    for (int i = 0; i < 52; i++) if (!seen[i]) exp_last = i;
    draw_one();
    chk("last_idx",   bus.card_idx, exp_last);
    chk("last_lat53", (last_lat <= 53), 1);
    chk("last_left",  bus.cards_left, 0);

    // Shuffle while probing: draw dropped, deck refilled.
    shuffle_deck(16'h1234);
    v0 = n_valid;
    bus.draw_req = 1'b1;
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
    bus.seed = 16'h0000;
    bus.shuffle = 1'b1;
    @(posedge clk); #1;
    bus.shuffle = 1'b0;
    chk("shuf_left", bus.cards_left, 52);
    repeat (4) begin @(posedge clk); #1; end
    chk("shuf_novalid", n_valid - v0, 0);
    draw_one();
    chk("shuf_redraw", n_valid - v0, 1);
    chk("shuf_left51", bus.cards_left, 51);

    // Reset while probing.
    v0 = n_valid;
    bus.draw_req = 1'b1;
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("rst_probe");
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_novalid", n_valid - v0, 0);
    draw_one();
    chk("rst_redraw", n_valid - v0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Draws random, never-repeated cards from a 52-card deck for the blackjack game controller. Holds a 52-bit used mask, a 16-bit LFSR for randomness, and a probe FSM that finds the next free card deterministically. Each draw returns the card's deck index and 7-bit card code through a request/valid handshake. Sits between the game FSM (player/dealer hit logic) and the hand-scoring logic.

## Interface
Parameters:
- SEED_DEFAULT, 16'h0001: LFSR value after reset.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- rst  in  1  reset; synchronous, active-high.
- shuffle  in  1  one-cycle pulse: new deck, reload LFSR from seed.
- seed  in  16  LFSR load value sampled on shuffle; 0 is replaced by 16'h0001.
- draw_req  in  1  level request for one card.
- draw_ready  out  1  combinational: state==IDLE && !shuffle.
- card_valid  out  1  one-cycle pulse; card_idx/card_code are valid.
- card_idx  out  6  deck index 0–51; holds until the next card_valid.
- card_code  out  7  bit6=1 (dealt), bits5:4 suit (00 spade, 01 heart, 10 diamond, 11 club), bits3:0 value (A=11, 2–9 face value, 10/J/Q/K=10); holds.
- cards_left  out  6  undealt cards, 52..0.
- draw_err  out  1  one-cycle pulse: draw accepted on an empty deck (macro off only).

## Operation
- LFSR: Fibonacci, shifts left every cycle; new bit0 = b15^b13^b12^b10. It never sits at 0.
- A draw is accepted when draw_req && draw_ready, in cycle T.
- At T, the candidate is lfsr[5:0], minus 52 if it is ≥52. The candidate is registered.
- FSM states:
  - IDLE: wait for an accepted draw. Go to PROBE if cards_left>0. Otherwise handle the empty-deck case (see Configuration).
  - PROBE: if used[cand]==0, set used[cand], decrement cards_left, latch card_idx/card_code, and go to DONE. Otherwise set cand = (cand==51) ? 0 : cand+1 and stay in PROBE.
  - DONE: assert card_valid and return to IDLE.
- Card code is derived from idx: suit = idx/13, rank = idx%13. Value is 11 if rank==0, 10 if rank≥9, else rank+1. Bit6 is forced to 1.
- shuffle has the highest priority, in any state. Next cycle: used mask cleared, cards_left=52, lfsr=seed (or 1 if seed is 0), state IDLE. An in-flight draw is dropped with no card_valid. card_idx/card_code keep their old values.
- shuffle and draw_req in the same cycle: the draw is not accepted.

## Timing
- Reset values: state IDLE, used mask all 0, cards_left=52, lfsr=SEED_DEFAULT, card_valid=0, draw_err=0, card_idx=0, card_code=0. draw_ready=1 in the cycle after rst falls.
- Latency: card_valid at T+2+k, where k is the number of used cards probed past (0 ≤ k ≤ 51). Worst case is T+53.
- cards_left and the used mask update at the PROBE→DONE edge, so they are visible together with card_valid.
- draw_ready is low from T+1 through the DONE cycle and high again the cycle after card_valid.
- Holding draw_req high gives back-to-back draws, one every 3+k cycles.
- rst mid-PROBE: returns to the reset state next cycle, with no card_valid.

## Configuration
- DEALER_AUTO_RESHUFFLE_EN defined: a draw accepted with cards_left==0 clears the used mask and reloads cards_left=52 at T+1 (the LFSR is not reloaded). It then proceeds in PROBE as normal. draw_err stays 0.
- DEALER_AUTO_RESHUFFLE_EN undefined: a draw accepted with cards_left==0 pulses draw_err at T+1. State stays IDLE, there is no card_valid, and draw_ready=1 at T+1.

## Structure
- Package card_pkg holds:
  - constants DECK_SIZE=52 and SUIT_SIZE=13;
  - the suit enum (SPADE, HEART, DIAMOND, CLUB);
  - a card_t packed struct {used, suit[1:0], value[3:0]};
  - the dealer state enum;
  - the LFSR tap constant.
- Sub-module card_lfsr: 16-bit LFSR with load/seed input and zero-seed guard. The used mask, probe logic and code derivation live in card_dealer.

## Test plan
- Reset, shuffle with seed 16'hACE1, then 52 draws → 52 card_valid pulses, all card_idx distinct, cards_left 52→0 exactly, every card_code bit6=1.
- Code mapping across the full deal: idx 0→7'h4B, idx 13→7'h5B, idx 22→7'h5A, idx 51→7'h7A, idx 27→7'h62.
- 53rd draw: macro off → draw_err at T+1, no card_valid. Macro on → card_valid arrives and cards_left=51 afterwards.
- Collision: shuffle with seed 16'h0001, deal 51 cards, then draw the last card → card_idx equals the single unused index, and latency ≤53 cycles.
- shuffle asserted in a PROBE cycle → no card_valid, cards_left=52 next cycle, next draw accepted normally.
- rst asserted mid-PROBE for one cycle → all outputs at reset values, draw_ready=1 the cycle after rst falls.
